// File: rtl/feeder_pkg.sv
// Shared types and constants for the MAC operand feeder: operand width, mode
// encodings, FSM states and FP16 exponent field positions.
package feeder_pkg;

  localparam int DW = 16;

  localparam logic MODE_INT8 = 1'b0;
  localparam logic MODE_FP16 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         FP16_EXP_MSB  = 14;
  localparam int         FP16_EXP_LSB  = 10;
  localparam logic [4:0] FP16_EXP_ALL1 = 5'h1F;

  // An all-ones exponent encodes Inf or NaN.
  function automatic logic is_inf_nan(input logic [DW-1:0] word);
    return word[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_ALL1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Valid+data delay line of DEPTH registers; shifts every cycle and clears
// on synchronous reset.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = feeder_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          tap_valid,
  output logic [DW-1:0] tap_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]    data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int j = 0; j < DEPTH; j++) data_q[j] <= '0;
    end else begin
      valid_q[0] <= load_valid;
      data_q[0]  <= load_data;
      for (int j = 1; j < DEPTH; j++) begin
        valid_q[j] <= valid_q[j-1];
        data_q[j]  <= data_q[j-1];
      end
    end
  end

  assign tap_valid = valid_q[DEPTH-1];
  assign tap_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mac_operand_feeder.sv
// Skews a stream of ROWS-wide operand vectors into a diagonal wavefront for
// the MAC array edge. Optional FP16 Inf/NaN flag: FEEDER_FP16_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start with non-zero k_len
// FEED  | accepting k_len operand vectors
// FLUSH | ROWS-1 cycles while the deepest lanes drain
// DONE  | one cycle, tile_done asserted
module mac_operand_feeder #(
  parameter int ROWS = 4,
  parameter int DW   = feeder_pkg::DW,
  parameter int KW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode_in,
  input  logic [KW-1:0]      k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] in_data,
  output logic [ROWS*DW-1:0] out_data,
  output logic [ROWS-1:0]    out_valid,
  output logic               mode,
  output logic               busy,
`ifdef FEEDER_FP16_CHECK_EN
  output logic               op_error,
`endif
  output logic               tile_done
);

  import feeder_pkg::*;

  localparam int FW = $clog2(ROWS);

  state_t        state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          accept;
  logic          start_ok;

  assign accept   = in_valid & in_ready;
  assign start_ok = (state == IDLE) & start & (k_len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      mode      <= MODE_INT8;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      tile_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= FEED;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            k_len_q  <= k_len;
            mode     <= mode_in;
            beat_cnt <= '0;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_len_q) begin
              state     <= FLUSH;
              in_ready  <= 1'b0;
              flush_cnt <= FW'(ROWS - 2);
            end
          end
        end
        FLUSH: begin
          // Down-counter from ROWS-2 gives exactly ROWS-1 flush cycles.
          if (flush_cnt == '0) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Lane i gets i+1 stages; unaccepted cycles enter as zeroed bubbles.
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    skew_line #(
      .DEPTH(i + 1),
      .DW   (DW)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .load_valid(accept),
      .load_data (accept ? in_data[i*DW +: DW] : '0),
      .tap_valid (out_valid[i]),
      .tap_data  (out_data[i*DW +: DW])
    );
  end

`ifdef FEEDER_FP16_CHECK_EN
  logic beat_bad;

  always_comb begin
    beat_bad = 1'b0;
    for (int i = 0; i < ROWS; i++)
      if (is_inf_nan(in_data[i*DW +: DW])) beat_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      op_error <= 1'b0;
    else if (start_ok)
      op_error <= 1'b0;
    else if (accept && mode == MODE_FP16 && beat_bad)
      op_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder (ROWS=4); op_error scenario is built
// only when FEEDER_FP16_CHECK_EN is defined.
module tb_mac_operand_feeder;

  localparam int ROWS = 4;
  localparam int DW   = 16;
  localparam int KW   = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               mode_in;
  logic [KW-1:0]      k_len;
  logic               in_valid;
  logic               in_ready;
  logic [ROWS*DW-1:0] in_data;
  logic [ROWS*DW-1:0] out_data;
  logic [ROWS-1:0]    out_valid;
  logic               mode;
  logic               busy;
  logic               tile_done;
`ifdef FEEDER_FP16_CHECK_EN
  logic               op_error;
`endif

  int checks = 0;
  int errors = 0;

  mac_operand_feeder #(.ROWS(ROWS), .DW(DW), .KW(KW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode_in  (mode_in),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .mode     (mode),
    .busy     (busy),
`ifdef FEEDER_FP16_CHECK_EN
    .op_error (op_error),
`endif
    .tile_done(tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Distinct word per beat and lane so lane swaps and beat reordering show up.
  function automatic logic [DW-1:0] wrd(input int b, input int i);
    return DW'((b + 1) * 16'h0101) ^ DW'(i << 12);
  endfunction

  function automatic logic [ROWS*DW-1:0] vec(input int b);
    logic [ROWS*DW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = wrd(b, i);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode_in = 1'b1; k_len = 8'd3;
    in_valid = 1'b1; in_data = {ROWS{16'hBEEF}};
    step(); step();
    checks++;
    if ({in_ready, out_valid, mode, busy, tile_done} !== 8'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b mode=%b busy=%b done=%b data=%h required all 0",
               in_ready, out_valid, mode, busy, tile_done, out_data);
    end
`ifdef FEEDER_FP16_CHECK_EN
    checks++;
    if (op_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_op_error: got %b required 0", op_error);
    end
`endif
    rst = 1'b0; start = 1'b0; mode_in = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
  endtask

  // k_len=3, in_valid held high throughout (also in FLUSH, where it must be ignored).
  task automatic test_basic();
    logic [ROWS-1:0]    exp_v [8];
    logic [7:0]         exp_done;
    logic [ROWS*DW-1:0] exp_d;
    exp_v = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    exp_done = 8'b0100_0000;
    start = 1'b1; k_len = 8'd3; mode_in = 1'b0; in_valid = 1'b1; in_data = vec(7);
    step();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_d = '0;
      for (int i = 0; i < ROWS; i++)
        if (exp_v[c][i]) exp_d[i*DW +: DW] = wrd(c - i - 1, i);
      checks++;
      if (out_valid !== exp_v[c] || out_data !== exp_d) begin
        errors++;
        $display("FAIL basic_lanes c=%0d: valid=%b data=%h required valid=%b data=%h",
                 c, out_valid, out_data, exp_v[c], exp_d);
      end
      checks++;
      if (tile_done !== exp_done[c] || in_ready !== (c < 3) || busy !== (c < 7)) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d: done=%b ready=%b busy=%b required done=%b ready=%b busy=%b",
                 c, tile_done, in_ready, busy, exp_done[c], c < 3, c < 7);
      end
      in_valid = 1'b1; in_data = vec(c);
      step();
    end
    in_valid = 1'b0;
  endtask

  // k_len=4, two bubble cycles after the second beat; done lands 2 cycles later.
  task automatic test_gaps();
    logic [ROWS-1:0]    exp_v [11];
    logic [10:0]        exp_done;
    int                 bmap [6];
    logic [ROWS*DW-1:0] exp_d;
    exp_v = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1001,
              4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
    exp_done = 11'b010_0000_0000;
    bmap = '{0, 1, -1, -1, 2, 3};
    start = 1'b1; k_len = 8'd4; mode_in = 1'b0; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 11; c++) begin
      exp_d = '0;
      for (int i = 0; i < ROWS; i++)
        if (exp_v[c][i]) exp_d[i*DW +: DW] = wrd(bmap[c - i - 1], i);
      checks++;
      if (out_valid !== exp_v[c] || out_data !== exp_d) begin
        errors++;
        $display("FAIL gaps_lanes c=%0d: valid=%b data=%h required valid=%b data=%h",
                 c, out_valid, out_data, exp_v[c], exp_d);
      end
      checks++;
      if (tile_done !== exp_done[c] || in_ready !== (c < 6) || busy !== (c < 10)) begin
        errors++;
        $display("FAIL gaps_ctrl c=%0d: done=%b ready=%b busy=%b required done=%b ready=%b busy=%b",
                 c, tile_done, in_ready, busy, exp_done[c], c < 6, c < 10);
      end
      if (c < 6 && bmap[c] >= 0) begin
        in_valid = 1'b1; in_data = vec(bmap[c]);
      end else begin
        in_valid = 1'b0; in_data = {ROWS{16'hDEAD}};
      end
      step();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  // Ignored starts: k_len=0 in IDLE, then re-start during FEED and FLUSH.
  task automatic test_ignored_start();
    start = 1'b1; k_len = 8'd0; mode_in = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || mode !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_start: busy=%b ready=%b mode=%b required 0 0 0", busy, in_ready, mode);
    end
    start = 1'b1; k_len = 8'd2; mode_in = 1'b0;
    step();
    start = 1'b1; k_len = 8'd5; mode_in = 1'b1; in_valid = 1'b1; in_data = vec(0);
    step();
    checks++;
    if (mode !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_in_feed: mode=%b ready=%b busy=%b required 0 1 1", mode, in_ready, busy);
    end
    start = 1'b0; in_data = vec(1);
    step();
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL klen_not_relatched: ready=%b busy=%b required 0 1", in_ready, busy);
    end
    in_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (tile_done !== 1'b1 || mode !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_done: done=%b mode=%b required 1 0", tile_done, mode);
    end
    step();
    checks++;
    if (busy !== 1'b0 || tile_done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_idle: busy=%b done=%b required 0 0", busy, tile_done);
    end
  endtask

  // Reset while FLUSH still holds data in lanes 1..3, then a clean k_len=1 tile.
  task automatic test_reset_mid();
    logic [ROWS-1:0] exp_v [6];
    exp_v = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    start = 1'b1; k_len = 8'd2; mode_in = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = vec(0);
    step();
    in_data = vec(1);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 4'b0110 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_flush: valid=%b ready=%b busy=%b required 0110 0 1",
               out_valid, in_ready, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, mode, busy, tile_done} !== 8'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: ready=%b valid=%b mode=%b busy=%b done=%b data=%h required all 0",
               in_ready, out_valid, mode, busy, tile_done, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== '0 || tile_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet c=%0d: valid=%b done=%b busy=%b required 0 0 0",
                 c, out_valid, tile_done, busy);
      end
    end
    start = 1'b1; k_len = 8'd1; mode_in = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== exp_v[c] || tile_done !== (c == 4) ||
          (exp_v[c] == 4'b1000 && out_data[3*DW +: DW] !== wrd(5, 3))) begin
        errors++;
        $display("FAIL fresh_tile c=%0d: valid=%b done=%b lane3=%h required valid=%b done=%b",
                 c, out_valid, tile_done, out_data[3*DW +: DW], exp_v[c], c == 4);
      end
      in_valid = (c == 0); in_data = vec(5);
      step();
    end
    in_valid = 1'b0;
  endtask

  // FP16 tile then INT8 tile: mode changes only on the second honoured start.
  task automatic test_mode_hold();
    start = 1'b1; k_len = 8'd1; mode_in = 1'b1;
    step();
    start = 1'b0; mode_in = 1'b0; in_valid = 1'b1; in_data = vec(2);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    checks++;
    if (tile_done !== 1'b1 || mode !== 1'b1) begin
      errors++;
      $display("FAIL mode_at_done: done=%b mode=%b required 1 1", tile_done, mode);
    end
    step(); step(); step();
    checks++;
    if (mode !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_held_idle: mode=%b busy=%b required 1 0", mode, busy);
    end
    start = 1'b1; mode_in = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (mode !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mode_second_start: mode=%b busy=%b required 0 1", mode, busy);
    end
    in_valid = 1'b1; in_data = vec(3);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
  endtask

`ifdef FEEDER_FP16_CHECK_EN
  task automatic test_fp16_check();
    logic [ROWS*DW-1:0] bad_vec;
    logic [ROWS*DW-1:0] ok_vec;
    bad_vec = {16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00};
    ok_vec  = {16'h7BFF, 16'h3C00, 16'hFBFF, 16'h0001};
    start = 1'b1; k_len = 8'd3; mode_in = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = ok_vec;
    step();
    checks++;
    if (op_error !== 1'b0) begin
      errors++;
      $display("FAIL fp16_finite_word: got %b required 0", op_error);
    end
    in_data = bad_vec;
    step();
    checks++;
    if (op_error !== 1'b1) begin
      errors++;
      $display("FAIL fp16_inf_set: got %b required 1", op_error);
    end
    in_data = ok_vec;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (op_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fp16_sticky: op_error=%b busy=%b required 1 0", op_error, busy);
    end
    start = 1'b1; k_len = 8'd1; mode_in = 1'b0;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = bad_vec;
    checks++;
    if (op_error !== 1'b0) begin
      errors++;
      $display("FAIL fp16_clear_on_start: got %b required 0", op_error);
    end
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (op_error !== 1'b0) begin
      errors++;
      $display("FAIL int8_no_error: got %b required 0", op_error);
    end
    for (int c = 0; c < 5; c++) step();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mode_in = 1'b0; k_len = '0;
    in_valid = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_ignored_start();
    test_reset_mid();
    test_mode_hold();
`ifdef FEEDER_FP16_CHECK_EN
    test_fp16_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
